serial_ring_memory: RTL and testbench



---
 rtl/serial_ring_memory.sv | 133 +++++++++++++
 tb/tb_serial_ring_memory.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_ring_memory.sv
// serial_ring_memory: memory end of the bit-serial shift-register loop.
// Holds NUM_WORDS words as one LSB-first ring, tracks which logical address
// sits in slot 0, and offers a handshaked parallel scan port for readers
// that need a word while the loop is idle.
// Build option: define SRING_SCAN_EN to include the scan FSM and slot mux;
// without it the scan outputs are tied low and scan inputs are ignored.
module serial_ring_memory #(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned NUM_WORDS     = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic                     ser_in,
  output logic                     ser_out,
  input  logic                     clr,
  output logic [ADDRESS_WIDTH-1:0] head,
  output logic                     aligned,
  input  logic                     scan_req,
  input  logic [ADDRESS_WIDTH-1:0] scan_addr,
  output logic                     scan_busy,
  output logic                     scan_valid,
  output logic [DATA_WIDTH-1:0]    scan_data,
  output logic                     scan_miss
);

  localparam int unsigned RING_W  = NUM_WORDS * DATA_WIDTH;
  localparam int unsigned PHASE_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DATA_WIDTH - 1);

  logic [RING_W-1:0]        r_ring;
  logic [ADDRESS_WIDTH-1:0] r_head;
  logic [PHASE_W-1:0]       r_phase;

  // Ring storage, bit phase and head pointer; clr wins over shift_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ring  <= '0;
      r_head  <= ADDRESS_WIDTH'(1);
      r_phase <= '0;
    end else if (clr) begin
      r_ring  <= '0;
    end else if (shift_en) begin
      r_ring <= {ser_in, r_ring[RING_W-1:1]};
      if (r_phase == PHASE_LAST) begin
        r_phase <= '0;
        r_head  <= r_head + ADDRESS_WIDTH'(1);
      end else begin
        r_phase <= r_phase + PHASE_W'(1);
      end
    end
  end

  assign ser_out = r_ring[0];
  assign head    = r_head;
  assign aligned = (r_phase == '0);

`ifdef SRING_SCAN_EN
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_RESULT  = 2'd2;

  logic [1:0]               r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     r_miss;

  logic [ADDRESS_WIDTH-1:0] w_slot;
  logic [DATA_WIDTH-1:0]    w_word;
  logic                     w_miss;
  logic                     w_fire;

  // Physical slot of the requested logical address relative to the head.
  assign w_slot = r_addr - r_head;

  // Slot mux; any slot past the stored words lives in the controller buffer.
  always_comb begin
    w_word = '0;
    w_miss = 1'b1;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (w_slot == ADDRESS_WIDTH'(k)) begin
        w_word = r_ring[k*DATA_WIDTH +: DATA_WIDTH];
        w_miss = 1'b0;
      end
    end
  end

  assign w_fire = (r_state == S_PENDING) && !shift_en && !clr && (r_phase == '0);

  // Scan handshake: latch the address, wait for an idle aligned loop, strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_miss  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (scan_req) begin
            r_addr  <= scan_addr;
            r_state <= S_PENDING;
          end
        end
        S_PENDING: begin
          if (w_fire) begin
            r_data  <= w_word;
            r_miss  <= w_miss;
            r_state <= S_RESULT;
          end
        end
        S_RESULT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign scan_busy  = (r_state == S_PENDING);
  assign scan_valid = (r_state == S_RESULT);
  assign scan_data  = r_data;
  assign scan_miss  = r_miss;
`else
  logic w_unused_scan;
  assign w_unused_scan = ^{scan_req, scan_addr};

  assign scan_busy  = 1'b0;
  assign scan_valid = 1'b0;
  assign scan_data  = '0;
  assign scan_miss  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_ring_memory.sv
// Directed bench for serial_ring_memory at default parameters. Scan-port
// scenarios are only exercised when SRING_SCAN_EN is defined; otherwise the
// scan outputs are expected to stay low.
module tb_serial_ring_memory;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NW = 15;

  logic          clk = 1'b0;
  logic          rst, shift_en, ser_in, clr, scan_req;
  logic [AW-1:0] scan_addr;
  logic          ser_out, aligned, scan_busy, scan_valid, scan_miss;
  logic [AW-1:0] head;
  logic [DW-1:0] scan_data;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] words [NW];

  serial_ring_memory #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk(clk), .rst(rst), .shift_en(shift_en), .ser_in(ser_in), .ser_out(ser_out),
    .clr(clr), .head(head), .aligned(aligned), .scan_req(scan_req),
    .scan_addr(scan_addr), .scan_busy(scan_busy), .scan_valid(scan_valid),
    .scan_data(scan_data), .scan_miss(scan_miss)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; shift_en = 1'b0; ser_in = 1'b0; clr = 1'b0;
    scan_req = 1'b0; scan_addr = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    shift_en = 1'b1; ser_in = b;
    step();
    shift_en = 1'b0; ser_in = 1'b0;
  endtask

  task automatic load_words();
    for (int w = 0; w < NW; w++)
      for (int b = 0; b < DW; b++)
        shift_bit(words[w][b]);
  endtask

`ifdef SRING_SCAN_EN
  task automatic do_scan(input logic [AW-1:0] addr, input logic [DW-1:0] exp_d,
                         input logic exp_m, input string tag);
    scan_req = 1'b1; scan_addr = addr;
    step();
    scan_req = 1'b0;
    n_vec++;
    if (scan_busy !== 1'b1 || scan_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_wait: busy=%b valid=%b required busy=1 valid=0", tag, scan_busy, scan_valid);
    end
    step();
    n_vec++;
    if (scan_valid !== 1'b1 || scan_busy !== 1'b0 || scan_data !== exp_d || scan_miss !== exp_m) begin
      n_err++;
      $display("FAIL %s_result: valid=%b busy=%b data=%h miss=%b required valid=1 busy=0 data=%h miss=%b",
               tag, scan_valid, scan_busy, scan_data, scan_miss, exp_d, exp_m);
    end
    step();
    n_vec++;
    if (scan_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_strobe: valid=%b required 0", tag, scan_valid);
    end
  endtask
`endif

  task automatic test_reset();
    reset_dut();
    n_vec++;
    if (head !== 4'd1 || aligned !== 1'b1 || ser_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ring: head=%0d aligned=%b ser_out=%b required 1 1 0", head, aligned, ser_out);
    end
    n_vec++;
    if (scan_busy !== 1'b0 || scan_valid !== 1'b0 || scan_data !== 8'h00 || scan_miss !== 1'b0) begin
      n_err++;
      $display("FAIL reset_scan: busy=%b valid=%b data=%h miss=%b required 0 0 00 0",
               scan_busy, scan_valid, scan_data, scan_miss);
    end
`ifdef SRING_SCAN_EN
    do_scan(4'd3, 8'h00, 1'b0, "reset_addr3");
    do_scan(4'd0, 8'h00, 1'b1, "reset_addr0_miss");
`endif
  endtask

  task automatic test_shift_byte();
    logic [7:0] v;
    v = 8'hA5;
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (ser_out !== 1'b0) begin
        n_err++;
        $display("FAIL byte_ser_out[%0d]: got %b required 0", i, ser_out);
      end
      shift_bit(v[i]);
      if (i == 0) begin
        n_vec++;
        if (aligned !== 1'b0) begin
          n_err++;
          $display("FAIL byte_midword_aligned: got %b required 0", aligned);
        end
      end
    end
    n_vec++;
    if (head !== 4'd2 || aligned !== 1'b1) begin
      n_err++;
      $display("FAIL byte_head: head=%0d aligned=%b required 2 1", head, aligned);
    end
`ifdef SRING_SCAN_EN
    do_scan(4'd0, 8'hA5, 1'b0, "byte_slot14");
`endif
  endtask

  task automatic test_loopback();
    reset_dut();
    load_words();
    n_vec++;
    if (head !== 4'd0 || aligned !== 1'b1) begin
      n_err++;
      $display("FAIL loop_load_head: head=%0d aligned=%b required 0 1", head, aligned);
    end
    for (int i = 0; i < NW*DW; i++) begin
      n_vec++;
      if (ser_out !== words[i/DW][i%DW]) begin
        n_err++;
        $display("FAIL loop_pass1[%0d]: got %b required %b", i, ser_out, words[i/DW][i%DW]);
      end
      shift_en = 1'b1; ser_in = ser_out;
      step();
    end
    shift_en = 1'b0; ser_in = 1'b0;
    n_vec++;
    if (head !== 4'd15 || aligned !== 1'b1) begin
      n_err++;
      $display("FAIL loop_head: head=%0d aligned=%b required 15 1", head, aligned);
    end
`ifdef SRING_SCAN_EN
    // head=15: address a sits in slot (a+1) mod 16
    do_scan(4'd15, words[0], 1'b0, "loop_addr15");
    do_scan(4'd6,  words[7], 1'b0, "loop_addr6");
    do_scan(4'd13, words[14], 1'b0, "loop_addr13");
    do_scan(4'd14, 8'h00, 1'b1, "loop_addr14_miss");
`endif
    for (int i = 0; i < NW*DW; i++) begin
      n_vec++;
      if (ser_out !== words[i/DW][i%DW]) begin
        n_err++;
        $display("FAIL loop_pass2[%0d]: got %b required %b", i, ser_out, words[i/DW][i%DW]);
      end
      shift_bit(1'b0);
    end
    n_vec++;
    if (head !== 4'd14) begin
      n_err++;
      $display("FAIL loop_head_wrap: head=%0d required 14", head);
    end
  endtask

`ifdef SRING_SCAN_EN
  task automatic test_scan_pending();
    reset_dut();
    load_words();
    shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b0);
    // accept while the 4th shift happens
    shift_en = 1'b1; ser_in = 1'b0; scan_req = 1'b1; scan_addr = 4'd5;
    step();
    // a second request while pending must be ignored
    scan_addr = 4'd0;
    step();
    scan_req = 1'b0;
    step();
    shift_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (scan_busy !== 1'b1 || scan_valid !== 1'b0) begin
        n_err++;
        $display("FAIL pend_hold[%0d]: busy=%b valid=%b required 1 0", i, scan_busy, scan_valid);
      end
      step();
    end
    shift_bit(1'b0); shift_bit(1'b0);
    n_vec++;
    if (scan_busy !== 1'b1 || scan_valid !== 1'b0 || head !== 4'd1 || aligned !== 1'b1) begin
      n_err++;
      $display("FAIL pend_aligned: busy=%b valid=%b head=%0d aligned=%b required 1 0 1 1",
               scan_busy, scan_valid, head, aligned);
    end
    step();
    n_vec++;
    if (scan_valid !== 1'b1 || scan_data !== words[5] || scan_miss !== 1'b0 || scan_busy !== 1'b0) begin
      n_err++;
      $display("FAIL pend_result: valid=%b data=%h miss=%b busy=%b required 1 %h 0 0",
               scan_valid, scan_data, scan_miss, scan_busy, words[5]);
    end
    step();
    n_vec++;
    if (scan_valid !== 1'b0 || scan_busy !== 1'b0) begin
      n_err++;
      $display("FAIL pend_ignored_req: valid=%b busy=%b required 0 0", scan_valid, scan_busy);
    end
  endtask
`endif

  task automatic test_reset_mid();
    reset_dut();
    for (int i = 0; i < 4; i++) shift_bit(1'b1);
`ifdef SRING_SCAN_EN
    scan_req = 1'b1; scan_addr = 4'd3;
    step();
    scan_req = 1'b0;
    n_vec++;
    if (scan_busy !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_pending: busy=%b required 1", scan_busy);
    end
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (head !== 4'd1 || aligned !== 1'b1 || ser_out !== 1'b0 || scan_busy !== 1'b0 || scan_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_state: head=%0d aligned=%b ser_out=%b busy=%b valid=%b required 1 1 0 0 0",
               head, aligned, ser_out, scan_busy, scan_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (scan_valid !== 1'b0 || scan_busy !== 1'b0) begin
        n_err++;
        $display("FAIL rmid_no_valid[%0d]: valid=%b busy=%b required 0 0", i, scan_valid, scan_busy);
      end
    end
    for (int i = 0; i < NW*DW; i++) begin
      n_vec++;
      if (ser_out !== 1'b0) begin
        n_err++;
        $display("FAIL rmid_ring[%0d]: got %b required 0", i, ser_out);
      end
      shift_bit(1'b0);
    end
  endtask

  task automatic test_clr();
    for (int w = 0; w < NW; w++) words[w] = 8'hFF;
    reset_dut();
    load_words();
    shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1);
    n_vec++;
    if (ser_out !== 1'b1) begin
      n_err++;
      $display("FAIL clr_before: ser_out=%b required 1", ser_out);
    end
    clr = 1'b1; shift_en = 1'b1; ser_in = 1'b1;
    step();
    clr = 1'b0; shift_en = 1'b0; ser_in = 1'b0;
    n_vec++;
    if (head !== 4'd0 || aligned !== 1'b0 || ser_out !== 1'b0) begin
      n_err++;
      $display("FAIL clr_state: head=%0d aligned=%b ser_out=%b required 0 0 0", head, aligned, ser_out);
    end
    for (int i = 0; i < 5; i++) shift_bit(1'b0);
    n_vec++;
    if (head !== 4'd1 || aligned !== 1'b1) begin
      n_err++;
      $display("FAIL clr_phase: head=%0d aligned=%b required 1 1", head, aligned);
    end
`ifdef SRING_SCAN_EN
    do_scan(4'd1,  8'h00, 1'b0, "clr_addr1");
    do_scan(4'd9,  8'h00, 1'b0, "clr_addr9");
    do_scan(4'd15, 8'h00, 1'b0, "clr_addr15");
    do_scan(4'd0,  8'h00, 1'b1, "clr_addr0_miss");
`endif
    for (int i = 0; i < NW*DW; i++) begin
      n_vec++;
      if (ser_out !== 1'b0) begin
        n_err++;
        $display("FAIL clr_ring[%0d]: got %b required 0", i, ser_out);
      end
      shift_bit(1'b0);
    end
  endtask

  initial begin
    for (int w = 0; w < NW; w++) words[w] = 8'(8'h11 * (w + 1));
    test_reset();
    test_shift_byte();
    test_loopback();
`ifdef SRING_SCAN_EN
    test_scan_pending();
`endif
    test_reset_mid();
    test_clr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
